// File: rtl/random_word_collector.sv
// random_word_collector: receives bytes over a 4-phase handshake
// and packs WORD_BYTES of them, first byte in the LSB lane, into one
// word. The word is then offered downstream on a valid/ready interface.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   in_data      byte from the producer
//   in_valid     producer request
//   in_received  4-phase acknowledge back to the producer
//   word         packed word
//   word_valid   packed word available
//   word_ready   downstream accept
//   fault        sticky repeated-byte health flag
//
// Optional macro RANDOM_WORD_COLLECTOR_REPEAT_CHECK_EN enables the
// repeated-byte check. Without it, fault is tied to 0.
module random_word_collector #(
    parameter int WORD_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_received,
    output logic [8*WORD_BYTES-1:0] word,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic                    fault
);

    localparam int CW = $clog2(WORD_BYTES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   count;
    logic            take;
    logic            release_word;

    // A byte is captured only on the IDLE cycle that sees in_valid.
    assign take         = (state == IDLE) && in_valid;
    assign release_word = (state == FULL) && word_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                if (!in_valid) begin
                    if (count == CW'(WORD_BYTES)) begin
                        state_next = FULL;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            FULL: begin
                if (word_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_received = 1'b0;
        word_valid  = 1'b0;
        unique case (state)
            ACK:     in_received = 1'b1;
            FULL:    word_valid  = 1'b1;
            default: ;
        endcase
    end

    // Lane write uses the pre-increment count as lane index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            word  <= '0;
        end else if (take) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (count == CW'(i)) begin
                    word[8*i +: 8] <= in_data;
                end
            end
            count <= count + CW'(1);
        end else if (release_word) begin
            count <= '0;
        end
    end

`ifdef RANDOM_WORD_COLLECTOR_REPEAT_CHECK_EN
    logic [7:0] prev;
    logic [1:0] rep;
    logic       fault_q;

    // rep counts consecutive repeats of prev; it saturates at 3 and
    // the third repeat (four equal bytes) sets the sticky flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev    <= '0;
            rep     <= '0;
            fault_q <= 1'b0;
        end else if (take) begin
            prev <= in_data;
            if (in_data == prev) begin
                if (rep != 2'd3) begin
                    rep <= rep + 2'd1;
                end
                if (rep == 2'd2) begin
                    fault_q <= 1'b1;
                end
            end else begin
                rep <= '0;
            end
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_random_word_collector.sv
// tb_random_word_collector: table vectors, directed corner sequences
// and randomized traffic against a byte-queue reference model.
module tb_random_word_collector;

    localparam int WB = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      in_data;
    logic            in_valid;
    logic            in_received;
    logic [8*WB-1:0] word;
    logic            word_valid;
    logic            word_ready;
    logic            fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    random_word_collector #(.WORD_BYTES(WB)) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_received(in_received),
        .word(word),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .fault(fault)
    );

    // Reference model: lane contents, bytes in current word, and the
    // history of accepted bytes since reset (seeded with the 0x00 the
    // repeat checker starts from).
    logic [7:0] lanes [WB];
    int         n;
    logic [7:0] hist [$];

    function automatic void model_reset();
        for (int i = 0; i < WB; i++) lanes[i] = 8'h00;
        n = 0;
        hist.delete();
        hist.push_back(8'h00);
    endfunction

    function automatic void model_push(logic [7:0] b);
        lanes[n] = b;
        n++;
        hist.push_back(b);
    endfunction

    function automatic logic [8*WB-1:0] exp_word();
        logic [8*WB-1:0] w = '0;
        for (int i = 0; i < WB; i++) w = w | ({24'h0, lanes[i]} << (8 * i));
        return w;
    endfunction

    function automatic logic exp_fault();
`ifdef RANDOM_WORD_COLLECTOR_REPEAT_CHECK_EN
        for (int i = 0; i + 3 < hist.size(); i++) begin
            if (hist[i] == hist[i+1] && hist[i] == hist[i+2] &&
                hist[i] == hist[i+3]) return 1'b1;
        end
`endif
        return 1'b0;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Full handshake from IDLE; hold = extra cycles in_valid stays high.
    task automatic send_byte(logic [7:0] b, int hold, bit rnd_ready);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk); #1;
        chk("ack_rise", in_received, 1);
        model_push(b);
        chk("fault_cap", fault, exp_fault());
        for (int h = 0; h < hold; h++) begin
            in_data = 8'($urandom);
            if (rnd_ready) word_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk("ack_hold", in_received, 1);
        end
        word_ready = 1'b0;
        in_valid   = 1'b0;
        @(posedge clk); #1;
        chk("ack_fall", in_received, 0);
        chk("wv_lat", word_valid, (n == WB) ? 1 : 0);
        if (n == WB) chk("word", word, exp_word());
    endtask

    task automatic accept(int wait_cyc);
        for (int k = 0; k < wait_cyc; k++) begin
            @(posedge clk); #1;
            chk("wv_hold", word_valid, 1);
            chk("word_hold", word, exp_word());
        end
        word_ready = 1'b1;
        @(posedge clk); #1;
        word_ready = 1'b0;
        chk("wv_clear", word_valid, 0);
        n = 0;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #1;
        chk("rst_ack", in_received, 0);
        chk("rst_wv", word_valid, 0);
        chk("rst_word", word, 0);
        chk("rst_fault", fault, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [7:0]  b [WB];
        int          hold;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [4];

    initial begin
        vt[0].b = '{8'h11, 8'h22, 8'h33, 8'h44};
        vt[0].hold = 0; vt[0].exp = 32'h44332211;
        vt[1].b = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        vt[1].hold = 1; vt[1].exp = 32'hFF00FF00;
        vt[2].b = '{8'h80, 8'h01, 8'h7F, 8'hFE};
        vt[2].hold = 2; vt[2].exp = 32'hFE7F0180;
        vt[3].b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        vt[3].hold = 3; vt[3].exp = 32'hEFBEADDE;

        model_reset();
        rst        = 1'b0;
        in_valid   = 1'b1;
        in_data    = 8'h99;
        word_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("reset_ack", in_received, 0);
            chk("reset_wv", word_valid, 0);
            chk("reset_word", word, 0);
            chk("reset_fault", fault, 0);
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;

        // Table vectors.
        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < WB; k++) send_byte(vt[v].b[k], vt[v].hold, 1'b1);
            chk("vec_word", word, {32'h0, vt[v].exp});
            accept(v);
        end

        // Backpressure with a pending byte.
        for (int k = 0; k < WB; k++) send_byte(8'h10 + 8'(k), 0, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            chk("bp_ack", in_received, 0);
            chk("bp_word", word, exp_word());
            chk("bp_wv", word_valid, 1);
        end
        word_ready = 1'b1;
        @(posedge clk); #1;
        word_ready = 1'b0;
        chk("bp_release", word_valid, 0);
        n = 0;
        @(posedge clk); #1;
        chk("bp_take", in_received, 1);
        chk("bp_lane0", word[7:0], 8'h55);
        model_push(8'h55);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_fall", in_received, 0);
        send_byte(8'h66, 0, 1'b0);
        send_byte(8'h77, 0, 1'b0);
        send_byte(8'h88, 0, 1'b0);
        chk("bp_word_final", word, 32'h88776655);
        accept(0);

        // Slow producer.
        send_byte(8'hC1, 10, 1'b1);
        send_byte(8'hC2, 10, 1'b1);
        send_byte(8'hC3, 10, 1'b1);
        send_byte(8'hC4, 10, 1'b1);
        chk("slow_word", word, 32'hC4C3C2C1);
        accept(1);

        // Reset mid-word with acknowledge high.
        send_byte(8'h5A, 0, 1'b0);
        send_byte(8'hA5, 0, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h3C;
        @(posedge clk); #1;
        chk("mid_ack", in_received, 1);
        pulse_reset();
        send_byte(8'hA1, 0, 1'b0);
        send_byte(8'hA2, 1, 1'b0);
        send_byte(8'hA3, 0, 1'b0);
        send_byte(8'hA4, 2, 1'b0);
        chk("mid_word", word, 32'hA4A3A2A1);
        accept(0);

        // Four identical bytes.
        pulse_reset();
        for (int k = 0; k < WB; k++) send_byte(8'h7E, 0, 1'b0);
        chk("rep_word", word, 32'h7E7E7E7E);
`ifdef RANDOM_WORD_COLLECTOR_REPEAT_CHECK_EN
        chk("rep_fault", fault, 1);
`else
        chk("rep_fault", fault, 0);
`endif
        accept(0);

        // Randomized traffic.
        pulse_reset();
        for (int w = 0; w < 30; w++) begin
            for (int k = 0; k < WB; k++) begin
                logic [7:0] b;
                if ($urandom_range(0, 3) == 0) b = hist[hist.size()-1];
                else b = 8'($urandom);
                send_byte(b, $urandom_range(0, 4), 1'b1);
                if (k != WB - 1) begin
                    for (int g = $urandom_range(0, 2); g > 0; g--) begin
                        @(posedge clk); #1;
                        chk("gap_ack", in_received, 0);
                    end
                end
            end
            chk("rnd_fault", fault, exp_fault());
            accept($urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
